// File: rtl/nios_player_input_ctrl.sv
// Avalon-MM player button controller: per-bit synchronize, tick-based debounce,
// edge capture into a W1C register and a maskable level interrupt.
module nios_player_input_ctrl #(
  parameter int TICK_DIV = 50000,
  parameter int P_WIDTH  = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  input  logic [P_WIDTH-1:0] in_player1,
  input  logic [P_WIDTH-1:0] in_player2,
  output logic               irq
);

  localparam int N  = 2 * P_WIDTH;
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    ADDR_STATE = 2'd0,
    ADDR_EDGE  = 2'd1,
    ADDR_MASK  = 2'd2,
    ADDR_CTRL  = 2'd3
  } reg_addr_e;

  reg_addr_e       addr;
  logic            wr;
  logic [N-1:0]    raw, sync1, sync2;
  logic [N-1:0]    h0, h1, h2;
  logic [N-1:0]    deb, edge_q, mask_q;
  logic [N-1:0]    agree, upd, rise, fall, edge_set, edge_clr;
  logic [CW-1:0]   cnt;
  logic            tick, tick_d;
  logic            en, both, tick_seen;
  logic            irq_pending;
  logic [31:0]     rd_mux;

  assign addr = reg_addr_e'(address);
  assign wr   = chipselect & ~write_n;
  assign raw  = {in_player2, in_player1};
  assign tick = en && (cnt == CW'(TICK_DIV - 1));

  // A bit is accepted only when all three tick samples agree.
  assign agree    = ~(h0 ^ h1) & ~(h1 ^ h2);
  assign upd      = {N{tick_d}} & agree;
  assign rise     = upd & h0 & ~deb;
  assign fall     = upd & ~h0 & deb;
  assign edge_set = rise | (both ? fall : '0);
  assign edge_clr = (wr && addr == ADDR_EDGE) ? writedata[N-1:0] : '0;

  assign irq_pending = |(edge_q & mask_q);

  // NOTE: every state register below uses non-blocking assignments so that all
  // flops sample the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      tick_d <= 1'b0;
    end else begin
      tick_d <= tick;
      if (!en || tick) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

  // History is only shifted on a tick, so it survives a disable untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h0 <= '0;
      h1 <= '0;
      h2 <= '0;
    end else if (tick) begin
      h0 <= sync2;
      h1 <= h0;
      h2 <= h1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb    <= '0;
      edge_q <= '0;
    end else begin
      deb    <= (deb & ~upd) | (h0 & upd);
      edge_q <= (edge_q & ~edge_clr) | edge_set;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q    <= '0;
      en        <= 1'b1;
      both      <= 1'b0;
      tick_seen <= 1'b0;
    end else begin
      if (wr && addr == ADDR_MASK) mask_q <= writedata[N-1:0];
      if (wr && addr == ADDR_CTRL) begin
        en   <= writedata[0];
        both <= writedata[1];
      end
      // A tick arriving with the clear still marks the flag.
      tick_seen <= (tick_seen & ~(wr && addr == ADDR_CTRL && writedata[9])) | tick;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_STATE: rd_mux[N-1:0] = deb;
      ADDR_EDGE:  rd_mux[N-1:0] = edge_q;
      ADDR_MASK:  rd_mux[N-1:0] = mask_q;
      ADDR_CTRL: begin
        rd_mux[0] = en;
        rd_mux[1] = both;
        rd_mux[8] = irq_pending;
        rd_mux[9] = tick_seen;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= chipselect ? rd_mux : '0;
      irq      <= irq_pending;
    end
  end

endmodule

// File: tb/tb_nios_player_input_ctrl.sv
// Self-checking bench for nios_player_input_ctrl: directed scenarios plus
// randomized traffic compared every cycle against a behavioural model.
module tb_nios_player_input_ctrl;

  localparam int TICK_DIV = 4;
  localparam int P_WIDTH  = 8;
  localparam int N        = 2 * P_WIDTH;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [1:0]         address;
  logic               chipselect;
  logic               write_n;
  logic [31:0]        writedata;
  logic [31:0]        readdata;
  logic [P_WIDTH-1:0] in_player1;
  logic [P_WIDTH-1:0] in_player2;
  logic               irq;

  nios_player_input_ctrl #(.TICK_DIV(TICK_DIV), .P_WIDTH(P_WIDTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_player1 (in_player1),
    .in_player2 (in_player2),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: raw values wait two cycles in a queue, tick samples are
  // kept as a short list, and register values follow the documented rules.
  logic [N-1:0] pipe_q[$];
  logic [N-1:0] samp[3];
  int           phase;
  bit           m_pend;
  logic [N-1:0] m_d, m_edge, m_mask;
  bit           m_en, m_both, m_seen;
  logic [31:0]  m_rd;
  bit           m_irq;

  task automatic model_reset();
    pipe_q = {};
    pipe_q.push_back('0);
    pipe_q.push_back('0);
    for (int i = 0; i < 3; i++) samp[i] = '0;
    phase = 0; m_pend = 0;
    m_d = '0; m_edge = '0; m_mask = '0;
    m_en = 1; m_both = 0; m_seen = 0;
    m_rd = '0; m_irq = 0;
  endtask

  function automatic logic [31:0] model_reg(input logic [1:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      2'd0: v = 32'(m_d);
      2'd1: v = 32'(m_edge);
      2'd2: v = 32'(m_mask);
      default: v = {22'd0, m_seen, (|(m_edge & m_mask)), 6'd0, m_both, m_en};
    endcase
    return v;
  endfunction

  task automatic model_step();
    bit           wr, tick, pending;
    logic [N-1:0] set_v, clr_v, d_next;
    wr      = chipselect && !write_n;
    pending = |(m_edge & m_mask);
    tick    = m_en && (phase == TICK_DIV - 1);
    set_v   = '0;
    d_next  = m_d;
    if (m_pend) begin
      for (int b = 0; b < N; b++) begin
        if (samp[0][b] == samp[1][b] && samp[1][b] == samp[2][b]) begin
          if (samp[0][b] != m_d[b] && (samp[0][b] || m_both)) set_v[b] = 1'b1;
          d_next[b] = samp[0][b];
        end
      end
    end
    clr_v  = (wr && address == 2'd1) ? writedata[N-1:0] : '0;
    m_rd   = chipselect ? model_reg(address) : 32'd0;
    m_irq  = pending;
    m_edge = (m_edge & ~clr_v) | set_v;
    m_d    = d_next;
    if (wr && address == 2'd2) m_mask = writedata[N-1:0];
    if (tick) begin
      samp[2] = samp[1];
      samp[1] = samp[0];
      samp[0] = pipe_q[0];
    end
    void'(pipe_q.pop_front());
    pipe_q.push_back({in_player2, in_player1});
    phase  = m_en ? (tick ? 0 : phase + 1) : 0;
    m_pend = tick;
    m_seen = (m_seen && !(wr && address == 2'd3 && writedata[9])) || tick;
    if (wr && address == 2'd3) begin
      m_en   = writedata[0];
      m_both = writedata[1];
    end
  endtask

  // One clock: model advances with the inputs driven now, outputs checked after the edge.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check("readdata", readdata, m_rd);
    check("irq", {31'd0, irq}, {31'd0, m_irq});
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    cyc();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] v);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    cyc();
    v = readdata;
    chipselect = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v, st0;
    bit found;
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    address = '0; writedata = '0; in_player1 = '0; in_player2 = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset values.
    bus_read(2'd3, v); check("ctrl_reset", v, 32'h1);
    bus_read(2'd0, v); check("state_reset", v, 32'h0);
    check("irq_reset", {31'd0, irq}, 32'd0);

    // Stable press on player 1 bit 0, irq stays low with MASK=0.
    in_player1 = 8'h01;
    repeat (20) cyc();
    bus_read(2'd0, v); check("state_p1", v, 32'h1);
    bus_read(2'd1, v); check("edge_p1", v, 32'h1);
    check("irq_masked", {31'd0, irq}, 32'd0);

    // Masked press on player 2 bit 0 raises irq, W1C drops it.
    bus_write(2'd1, 32'hFFFF);
    bus_write(2'd2, 32'h0100);
    in_player2 = 8'h01;
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      cyc();
      if (irq) found = 1;
    end
    check("irq_rise_bound", {31'd0, found}, 32'd1);
    bus_read(2'd1, v); check("edge_p2", v, 32'h0100);
    bus_write(2'd1, 32'h0100);
    cyc();
    check("irq_cleared", {31'd0, irq}, 32'd0);

    // Bit 3 toggling every 3 cycles never gives three agreeing samples.
    for (int k = 0; k < 20; k++) begin
      in_player1[3] = ~in_player1[3];
      bus_read(2'd0, v); check("bounce_state", {31'd0, v[3]}, 32'd0);
      bus_read(2'd1, v); check("bounce_edge", {31'd0, v[3]}, 32'd0);
      cyc();
    end
    repeat (20) cyc();

    // Both-edge mode: clear collides with a falling edge, the set wins.
    bus_write(2'd1, 32'hFFFF);
    bus_write(2'd3, 32'h3);
    in_player1 = 8'h00;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (m_pend && !samp[0][0] && !samp[1][0] && !samp[2][0] && m_d[0]) begin
        found = 1;
        bus_write(2'd1, 32'h0001);
      end else begin
        cyc();
      end
    end
    check("fall_detect_bound", {31'd0, found}, 32'd1);
    bus_read(2'd1, v); check("set_wins", {31'd0, v[0]}, 32'd1);
    bus_read(2'd0, v); check("state_fell", {31'd0, v[0]}, 32'd0);

    // Disabled: state frozen, tick_seen stays clear.
    bus_write(2'd3, 32'h0);
    bus_write(2'd3, 32'h200);
    bus_read(2'd0, st0);
    in_player1 = 8'hFF; in_player2 = 8'hAA;
    repeat (20) cyc();
    bus_read(2'd0, v); check("state_frozen", v, st0);
    bus_read(2'd3, v);
    check("tick_seen_off", {31'd0, v[9]}, 32'd0);
    check("en_off", {31'd0, v[0]}, 32'd0);

    // Reset mid-count with readdata and irq active.
    bus_write(2'd3, 32'h1);
    bus_write(2'd2, 32'hFFFF);
    repeat (25) cyc();
    chipselect = 1'b1; write_n = 1'b1; address = 2'd0;
    cyc();
    check("pre_reset_state", readdata, 32'hAAFF);
    #2 reset_n = 1'b0;
    #1;
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    chipselect = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(2'd3, v); check("ctrl_after_rst", v, 32'h1);
    bus_read(2'd2, v); check("mask_after_rst", v, 32'h0);

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      int op;
      if ($urandom_range(0, 9) == 0) begin
        in_player1 = 8'($urandom);
        in_player2 = 8'($urandom);
      end
      op = $urandom_range(0, 9);
      if (op < 5) begin
        cyc();
      end else if (op < 8) begin
        bus_read(2'($urandom_range(0, 3)), v);
      end else begin
        logic [1:0]  a;
        logic [31:0] d;
        a = 2'($urandom_range(0, 3));
        d = $urandom;
        if (a == 2'd3) d[0] = ($urandom_range(0, 5) != 0);
        bus_write(a, d);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
